vga_timing_pattern: RTL and testbench

//  Parametrised successor to the fixed 1-bit VGA display. Generates H/V sync and data-enable
//  for any timing set, plus pixel coordinates and a runtime-selectable test pattern at COLOR_W bits per channel.

---
 rtl/vga_timing_pattern.sv | 182 ++++++++++++++++++
 tb/tb_vga_timing_pattern.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_pattern.sv
// vga_timing_pattern: parametrised VGA timing generator with a selectable test
// pattern. The horizontal and vertical counters form the timing base. Every
// output is registered from the counters and from the frame-latched mode, so
// sync, data-enable, coordinates and colour stay aligned with a fixed 1-clock
// latency.
module vga_timing_pattern #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 4,
  parameter int CHK_LOG2 = 3
) (
  input  logic                 clk_pix,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic                 vga_hs,
  output logic                 vga_vs,
  output logic                 vga_de,
  output logic [COLOR_W-1:0]   vga_r,
  output logic [COLOR_W-1:0]   vga_g,
  output logic [COLOR_W-1:0]   vga_b,
  output logic [11:0]          pix_x,
  output logic [11:0]          pix_y,
  output logic                 frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT      = 12'(V_ACTIVE);
  localparam logic [11:0] H_ACT_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START   = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END     = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] BAR_LAST   = 12'(BAR_W - 1);

  localparam logic [1:0] MODE_BARS     = 2'd0;
  localparam logic [1:0] MODE_CHECKER  = 2'd1;
  localparam logic [1:0] MODE_GRADIENT = 2'd2;

  logic [11:0]        h_cnt;
  logic [11:0]        v_cnt;
  logic [11:0]        bar_px;     // pixel offset inside the current colour bar
  logic [2:0]         bar_k;      // index of the bar that h_cnt lies in
  logic [1:0]         mode_q;

  logic               h_wrap;
  logic               frame_end;
  logic               active;
  logic               hs_on;
  logic               vs_on;
  logic [2:0]         bar_c;
  logic               chk_white;
  logic [COLOR_W-1:0] r_nxt;
  logic [COLOR_W-1:0] g_nxt;
  logic [COLOR_W-1:0] b_nxt;

  assign h_wrap    = (h_cnt == H_LAST);
  assign frame_end = h_wrap && (v_cnt == V_LAST);
  assign active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_on     = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_on     = (v_cnt >= VS_START) && (v_cnt < VS_END);
  // Bars run white..black, so the colour code 7-k is the bitwise inverse of k.
  assign bar_c     = ~bar_k;
  assign chk_white = h_cnt[CHK_LOG2] ^ v_cnt[CHK_LOG2];

  // Raster counters: h_cnt runs every clock, v_cnt steps when h_cnt wraps.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  // Bar tracker: follows h_cnt so the bar index needs no divider; it is
  // restarted at every line wrap and holds once the last bar is reached.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      bar_px <= '0;
      bar_k  <= '0;
    end else if (h_wrap) begin
      bar_px <= '0;
      bar_k  <= '0;
    end else if (h_cnt < H_ACT_LAST) begin
      if (bar_px == BAR_LAST) begin
        bar_px <= '0;
        bar_k  <= bar_k + 3'd1;
      end else begin
        bar_px <= bar_px + 12'd1;
      end
    end
  end

  // Pattern select is latched only on the last clock of the frame so a
  // frame is never drawn with two different patterns.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_BARS;
    end else if (frame_end) begin
      mode_q <= mode;
    end
  end

  // Pattern colour for the pixel at the current counter position.
  // NOTE: every output gets a default first, so no path can infer a latch;
  // blanking falls out of those defaults.
  always_comb begin
    r_nxt = '0;
    g_nxt = '0;
    b_nxt = '0;
    if (active) begin
      case (mode_q)
        MODE_BARS: begin
          r_nxt = {COLOR_W{bar_c[2]}};
          g_nxt = {COLOR_W{bar_c[1]}};
          b_nxt = {COLOR_W{bar_c[0]}};
        end
        MODE_CHECKER: begin
          r_nxt = {COLOR_W{chk_white}};
          g_nxt = {COLOR_W{chk_white}};
          b_nxt = {COLOR_W{chk_white}};
        end
        MODE_GRADIENT: begin
          r_nxt = h_cnt[COLOR_W-1:0];
          g_nxt = v_cnt[COLOR_W-1:0];
          b_nxt = h_cnt[COLOR_W-1:0] ^ v_cnt[COLOR_W-1:0];
        end
        default: begin
          r_nxt = solid_rgb[3*COLOR_W-1:2*COLOR_W];
          g_nxt = solid_rgb[2*COLOR_W-1:COLOR_W];
          b_nxt = solid_rgb[COLOR_W-1:0];
        end
      endcase
    end
  end

  // Output register stage: all video outputs share the same single clock of latency.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs      <= ~HS_POL;
      vga_vs      <= ~VS_POL;
      vga_de      <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      vga_hs      <= hs_on ? HS_POL : ~HS_POL;
      vga_vs      <= vs_on ? VS_POL : ~VS_POL;
      vga_de      <= active;
      vga_r       <= r_nxt;
      vga_g       <= g_nxt;
      vga_b       <= b_nxt;
      pix_x       <= active ? h_cnt : 12'd0;
      pix_y       <= active ? v_cnt : 12'd0;
      frame_start <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
    end
  end

endmodule

// File: tb/tb_vga_timing_pattern.sv
// tb_vga_timing_pattern: directed frames plus randomised mode/colour traffic,
// every output checked each clock against a raster-position reference model.
module tb_vga_timing_pattern;

  localparam int HA = 16, HF = 2, HSY = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VSY = 2, VB = 1;
  localparam int HT = HA + HF + HSY + HB;   // 24
  localparam int VT = VA + VF + VSY + VB;   // 12
  localparam int FT = HT * VT;              // 288
  localparam int CW = 4;

  logic          clk_pix = 1'b0;
  logic          rst_n;
  logic [1:0]    mode;
  logic [11:0]   solid_rgb;
  logic          vga_hs, vga_vs, vga_de, frame_start;
  logic [CW-1:0] vga_r, vga_g, vga_b;
  logic [11:0]   pix_x, pix_y;

  int n_cmp = 0;
  int n_bad = 0;
  int pos;     // raster position the DUT counters hold before the next edge
  int fmode;   // pattern the model believes is latched for this frame

  logic [11:0] obs_rgb [FT];
  logic [23:0] obs_pix [FT];
  logic        obs_de  [FT];
  logic        obs_hs  [FT];
  logic        obs_vs  [FT];
  logic        obs_fs  [FT];

  vga_timing_pattern #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(CW), .CHK_LOG2(1)
  ) dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .mode(mode), .solid_rgb(solid_rgb),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Colour of a raster position: bars of HA/8 pixels, checker squares of 2 pixels.
  function automatic logic [11:0] ref_rgb(input int hp, input int vp, input int md,
                                          input logic [11:0] solid);
    logic [2:0] c;
    logic [3:0] r, g;
    if (hp >= HA || vp >= VA) return 12'h000;
    case (md)
      0: begin
        c = 3'(7 - hp / (HA / 8));
        return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
      end
      1: return (((hp / 2) + (vp / 2)) % 2 == 1) ? 12'hFFF : 12'h000;
      2: begin
        r = 4'(hp % 16);
        g = 4'(vp % 16);
        return {r, g, r ^ g};
      end
      default: return solid;
    endcase
  endfunction

  // One clock: predict the outputs for the current position, clock, compare.
  task automatic tick();
    int          hp, vp;
    logic        e_de, e_hs, e_vs, e_fs;
    logic [11:0] e_rgb, ex, ey;
    logic [1:0]  mode_at_edge;
    hp    = pos % HT;
    vp    = pos / HT;
    e_de  = (hp < HA) && (vp < VA);
    e_hs  = !((hp >= HA + HF) && (hp < HA + HF + HSY));
    e_vs  = !((vp >= VA + VF) && (vp < VA + VF + VSY));
    e_fs  = (pos == 0);
    e_rgb = ref_rgb(hp, vp, fmode, solid_rgb);
    ex    = e_de ? 12'(hp) : 12'd0;
    ey    = e_de ? 12'(vp) : 12'd0;
    mode_at_edge = mode;
    @(posedge clk_pix);
    #1;
    chk($sformatf("de@%0d", pos), vga_de, e_de);
    chk($sformatf("hs@%0d", pos), vga_hs, e_hs);
    chk($sformatf("vs@%0d", pos), vga_vs, e_vs);
    chk($sformatf("fs@%0d", pos), frame_start, e_fs);
    chk($sformatf("rgb@%0d", pos), {vga_r, vga_g, vga_b}, e_rgb);
    chk($sformatf("px@%0d", pos), pix_x, ex);
    chk($sformatf("py@%0d", pos), pix_y, ey);
    obs_rgb[pos] = {vga_r, vga_g, vga_b};
    obs_pix[pos] = {pix_x, pix_y};
    obs_de[pos]  = vga_de;
    obs_hs[pos]  = vga_hs;
    obs_vs[pos]  = vga_vs;
    obs_fs[pos]  = frame_start;
    if (pos == FT - 1) fmode = int'(mode_at_edge);
    pos = (pos + 1) % FT;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_de"}, vga_de, 0);
    chk({tag, "_hs"}, vga_hs, 1);
    chk({tag, "_vs"}, vga_vs, 1);
    chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    chk({tag, "_px"}, pix_x, 0);
    chk({tag, "_py"}, pix_y, 0);
    chk({tag, "_fs"}, frame_start, 0);
  endtask

  // Sync widths/positions and frame pulse measured over the last captured frame.
  task automatic check_timing(input string tag);
    int hs_first = -1, hs_line = 0, hs_tot = 0;
    int vs_first = -1, vs_tot = 0, fs_tot = 0;
    for (int i = 0; i < HT; i++) begin
      if (!obs_hs[i]) begin
        if (hs_first < 0) hs_first = i;
        hs_line++;
      end
    end
    for (int i = 0; i < FT; i++) begin
      if (!obs_hs[i]) hs_tot++;
      if (!obs_vs[i]) begin
        if (vs_first < 0) vs_first = i;
        vs_tot++;
      end
      if (obs_fs[i]) fs_tot++;
    end
    chk({tag, "_hs_start"}, hs_first, 18);
    chk({tag, "_hs_len"}, hs_line, 3);
    chk({tag, "_hs_total"}, hs_tot, 3 * VT);
    chk({tag, "_vs_start"}, vs_first, (VA + VF) * HT);
    chk({tag, "_vs_len"}, vs_tot, 48);
    chk({tag, "_fs_count"}, fs_tot, 1);
    chk({tag, "_first_de"}, obs_de[0], 1);
    chk({tag, "_first_fs"}, obs_fs[0], 1);
    chk({tag, "_first_pix"}, obs_pix[0], 0);
  endtask

  initial begin
    int sw;
    int cnt;
    rst_n     = 1'b0;
    mode      = 2'd0;
    solid_rgb = 12'h000;
    pos       = 0;
    fmode     = 0;
    @(posedge clk_pix);
    #1;
    chk_reset("reset");
    @(negedge clk_pix);
    rst_n = 1'b1;

    // Frame 1: bars after reset; request checker for the next frame.
    sw = int'($urandom_range(10, 250));
    for (int i = 0; i < FT; i++) begin
      tick();
      if (i == sw) mode = 2'd1;
    end
    check_timing("f1");
    chk("bar_x0", obs_rgb[0], 12'hFFF);
    chk("bar_x1", obs_rgb[1], 12'hFFF);
    chk("bar_x2", obs_rgb[2], 12'hFF0);
    chk("bar_x3", obs_rgb[3], 12'hFF0);
    chk("bar_x14", obs_rgb[14], 12'h000);
    chk("bar_x15", obs_rgb[15], 12'h000);
    for (int i = HA; i < HT; i++) begin
      chk($sformatf("blank_rgb%0d", i), obs_rgb[i], 12'h000);
      chk($sformatf("blank_de%0d", i), obs_de[i], 0);
    end

    // Frame 2: checker; switch back to bars for frame 3.
    sw = int'($urandom_range(10, 250));
    for (int i = 0; i < FT; i++) begin
      tick();
      if (i == sw) mode = 2'd0;
    end
    chk("chk_x0", obs_rgb[0], 12'h000);
    chk("chk_x1", obs_rgb[1], 12'h000);
    chk("chk_x2", obs_rgb[2], 12'hFFF);
    chk("chk_x3", obs_rgb[3], 12'hFFF);
    chk("chk_l2_x0", obs_rgb[2 * HT], 12'hFFF);
    chk("chk_l2_x2", obs_rgb[2 * HT + 2], 12'h000);

    // Frame 3: switch to solid at line 3; the rest of this frame stays bars.
    run(3 * HT);
    mode      = 2'd3;
    solid_rgb = 12'hA5C;
    run(FT - 3 * HT);
    chk("midframe_bar", obs_rgb[5 * HT + 2], 12'hFF0);
    chk("midframe_bar_end", obs_rgb[7 * HT + 15], 12'h000);

    // Frame 4: solid colour everywhere active; request gradient next.
    sw = int'($urandom_range(10, 250));
    for (int i = 0; i < FT; i++) begin
      tick();
      if (i == sw) mode = 2'd2;
    end
    cnt = 0;
    for (int i = 0; i < FT; i++) if (obs_de[i] && obs_rgb[i] == 12'hA5C) cnt++;
    chk("solid_count", cnt, HA * VA);

    // Frame 5: gradient.
    run(FT);
    chk("grad_5_3", obs_rgb[3 * HT + 5], 12'h536);
    chk("grad_blank", obs_rgb[HA], 12'h000);
    chk("grad_15_7", obs_rgb[7 * HT + 15], 12'hF78);

    // Random traffic: live solid colour every clock, occasional mode changes.
    for (int i = 0; i < 4 * FT; i++) begin
      tick();
      solid_rgb = 12'($urandom);
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom);
    end

    // Asynchronous reset mid-frame, just after pixel (7,5) was output.
    run(5 * HT + 8);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    @(posedge clk_pix);
    #1;
    chk_reset("held");
    mode = 2'd1;
    @(negedge clk_pix);
    rst_n = 1'b1;
    pos   = 0;
    fmode = 0;
    run(FT);
    check_timing("rst_f1");
    chk("rst_bar_x0", obs_rgb[0], 12'hFFF);
    chk("rst_bar_x2", obs_rgb[2], 12'hFF0);
    run(FT);
    check_timing("rst_f2");
    chk("rst_chk_x2", obs_rgb[2], 12'hFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
